// File: rtl/sprite_pkg.sv
// Shared sprite-table definitions: entry type codes, entry field positions,
// FSM state encodings and the entry packing helper.
package sprite_pkg;

  localparam logic [5:0] SPR_CHARGE_FILLED = 6'h13;
  localparam logic [5:0] SPR_CHARGE_EMPTY  = 6'h14;
  localparam logic [5:0] SPR_NONE          = 6'h00;

  // Entry layout: [31:26] type, [25:24] zero, [23:14] X right edge
  // (exclusive), [13:4] Y top, [3:0] zero.
  localparam int ENT_TYPE_LSB = 26;
  localparam int ENT_X_LSB    = 14;
  localparam int ENT_Y_LSB    = 4;

  typedef enum logic {CH_IDLE, CH_CHARGING} charge_state_e;
  typedef enum logic {R_IDLE, R_WRITE} refresh_state_e;

  function automatic logic [31:0] pack_entry(input logic [5:0] spr_type,
                                             input logic [9:0] x_right,
                                             input logic [9:0] y_top);
    logic [31:0] word;
    word = '0;
    word[ENT_TYPE_LSB +: 6] = spr_type;
    word[ENT_X_LSB +: 10]   = x_right;
    word[ENT_Y_LSB +: 10]   = y_top;
    return word;
  endfunction

endpackage

// File: rtl/table_write_sequencer.sv
// Refresh sequencer: once per frame sweeps NUM_UNITS table writes.
// Handshake: tbl_we_o is a valid; tbl_addr_o/tbl_data_o are held stable
// while tbl_we_o=1 and advance only in a cycle where tbl_ack_o... rather
// tbl_ack_i=1 (the ready). tbl_ack_i is ignored while tbl_we_o=0.
// The entry for the unit about to be loaded is computed outside from
// load_idx_o/load_level_o/load_en_o and fed back on entry_*_i.
module table_write_sequencer
  import sprite_pkg::*;
#(
  parameter int NUM_UNITS = 10
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           frame_tick_i,
  input  logic [3:0]     level_i,
  input  logic           enable_i,
  input  logic [5:0]     entry_addr_i,
  input  logic [31:0]    entry_data_i,
  input  logic           tbl_ack_i,
  output logic [3:0]     load_idx_o,
  output logic [3:0]     load_level_o,
  output logic           load_en_o,
  output logic           tbl_we_o,
  output logic [5:0]     tbl_addr_o,
  output logic [31:0]    tbl_data_o,
  output refresh_state_e state_o
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_UNITS - 1);

  refresh_state_e state_q, state_d;
  logic           pending_q, pending_d;
  logic [3:0]     idx_q, idx_d;
  logic [3:0]     snap_level_q, snap_level_d;
  logic           snap_en_q, snap_en_d;
  logic [5:0]     addr_q, addr_d;
  logic [31:0]    data_q, data_d;
  logic           load;

  // Next-state: start a sweep on a pending (or same-cycle) tick, advance on ack.
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q | frame_tick_i;
    idx_d        = idx_q;
    snap_level_d = snap_level_q;
    snap_en_d    = snap_en_q;
    load         = 1'b0;
    case (state_q)
      R_IDLE: begin
        if (pending_q || frame_tick_i) begin
          pending_d    = 1'b0;
          idx_d        = 4'd0;
          snap_level_d = level_i;
          snap_en_d    = enable_i;
          load         = 1'b1;
          state_d      = R_WRITE;
        end
      end
      R_WRITE: begin
        if (tbl_ack_i) begin
          if (idx_q == LAST_IDX) begin
            state_d = R_IDLE;
          end else begin
            idx_d = idx_q + 4'd1;
            load  = 1'b1;
          end
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  // Output registers reload only when a new entry is presented.
  always_comb begin
    addr_d = load ? entry_addr_i : addr_q;
    data_d = load ? entry_data_i : data_q;
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= R_IDLE;
      pending_q    <= 1'b0;
      idx_q        <= 4'd0;
      snap_level_q <= 4'd0;
      snap_en_q    <= 1'b0;
      addr_q       <= 6'd0;
      data_q       <= 32'd0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      idx_q        <= idx_d;
      snap_level_q <= snap_level_d;
      snap_en_q    <= snap_en_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
    end
  end

  assign load_idx_o   = idx_d;
  assign load_level_o = snap_level_d;
  assign load_en_o    = snap_en_d;
  assign tbl_we_o     = (state_q == R_WRITE);
  assign tbl_addr_o   = addr_q;
  assign tbl_data_o   = data_q;
  assign state_o      = state_q;

endmodule

// File: rtl/charge_bar_table_writer.sv
// Charging-bar producer: tracks shot charge while fire is held, emits a
// fire strobe on release, and refreshes one sprite-table entry per bar
// unit every frame through table_write_sequencer.
module charge_bar_table_writer
  import sprite_pkg::*;
#(
  parameter int         NUM_UNITS = 10,
  parameter int         UNIT_W    = 25,
  parameter logic [9:0] BAR_X0    = 10'd100,
  parameter logic [9:0] BAR_Y     = 10'd440,
  parameter logic [5:0] BASE_ADDR = 6'd32,
  parameter int         TICK_DIV  = 4
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        frame_tick,
  input  logic        charge_enable,
  input  logic        charge_hold,
  output logic [3:0]  level_out,
  output logic        fire_pulse,
  output logic [3:0]  fire_level,
  output logic        tbl_we,
  output logic [5:0]  tbl_addr,
  output logic [31:0] tbl_data,
  input  logic        tbl_ack,
  output logic        dbg_charge_state,
  output logic        dbg_refresh_state
);

  localparam int               DIV_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [3:0]       MAX_LEVEL = 4'(NUM_UNITS);

  charge_state_e    state_q, state_d;
  logic [3:0]       level_q, level_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             fire_pulse_q, fire_pulse_d;
  logic [3:0]       fire_level_q, fire_level_d;

  // Charge FSM: losing the turn overrides everything, then release, then ticks.
  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    div_d        = div_q;
    fire_pulse_d = 1'b0;
    fire_level_d = fire_level_q;
    if (!charge_enable) begin
      state_d = CH_IDLE;
      level_d = 4'd0;
      div_d   = '0;
    end else begin
      case (state_q)
        CH_IDLE: begin
          if (charge_hold) begin
            state_d = CH_CHARGING;
            div_d   = '0;
          end
        end
        CH_CHARGING: begin
          if (!charge_hold) begin
            if (level_q != 4'd0) begin
              fire_pulse_d = 1'b1;
              fire_level_d = level_q;
            end
            level_d = 4'd0;
            state_d = CH_IDLE;
          end else if (frame_tick) begin
            if (div_q == DIV_LAST) begin
              div_d = '0;
              if (level_q < MAX_LEVEL) level_d = level_q + 4'd1;
            end else begin
              div_d = div_q + 1'b1;
            end
          end
        end
        default: state_d = CH_IDLE;
      endcase
    end
  end

  // Charge FSM registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= CH_IDLE;
      level_q      <= 4'd0;
      div_q        <= '0;
      fire_pulse_q <= 1'b0;
      fire_level_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      div_q        <= div_d;
      fire_pulse_q <= fire_pulse_d;
      fire_level_q <= fire_level_d;
    end
  end

  // Entry generation for the unit the sequencer is about to present.
  logic [3:0]     load_idx;
  logic [3:0]     load_level;
  logic           load_en;
  logic [9:0]     entry_x;
  logic [5:0]     entry_type;
  logic [5:0]     entry_addr;
  logic [31:0]    entry_data;
  refresh_state_e seq_state;

  // Unit type from the sweep snapshot: hidden, filled below level, else empty.
  always_comb begin
    entry_type = SPR_NONE;
    if (load_en) entry_type = (load_idx < load_level) ? SPR_CHARGE_FILLED : SPR_CHARGE_EMPTY;
  end

  // Right edge is exclusive and wraps in 10 bits.
  assign entry_x    = BAR_X0 + ({6'd0, load_idx} + 10'd1) * 10'(UNIT_W);
  assign entry_addr = BASE_ADDR + {2'b00, load_idx};
  assign entry_data = pack_entry(entry_type, entry_x, BAR_Y);

  table_write_sequencer #(
    .NUM_UNITS (NUM_UNITS)
  ) u_seq (
    .clk_i        (Clk),
    .rst_ni       (Reset_n),
    .frame_tick_i (frame_tick),
    .level_i      (level_q),
    .enable_i     (charge_enable),
    .entry_addr_i (entry_addr),
    .entry_data_i (entry_data),
    .tbl_ack_i    (tbl_ack),
    .load_idx_o   (load_idx),
    .load_level_o (load_level),
    .load_en_o    (load_en),
    .tbl_we_o     (tbl_we),
    .tbl_addr_o   (tbl_addr),
    .tbl_data_o   (tbl_data),
    .state_o      (seq_state)
  );

  assign level_out         = level_q;
  assign fire_pulse        = fire_pulse_q;
  assign fire_level        = fire_level_q;
  assign dbg_charge_state  = state_q;
  assign dbg_refresh_state = seq_state;

endmodule
